// File: rtl/gate_input_debounce.sv
// Two-channel synchroniser and debouncer feeding and_gate din_a/din_b.
// Define GATE_DEBOUNCE_EDGE_EN for the rise_a/rise_b edge pulses.

module gate_input_debounce_ch #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [1:0] STABLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI   = 2'd1;
  localparam logic [1:0] STABLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO   = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             level_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    unique case (state)
      STABLE_LO: begin
        if (s2) begin
          state_n = WAIT_HI;
          cnt_n   = ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          level_n = 1'b1;
        end else begin
          cnt_n   = cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!s2) begin
          state_n = WAIT_LO;
          cnt_n   = ONE;
        end else begin
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          level_n = 1'b0;
        end else begin
          cnt_n   = cnt + ONE;
        end
      end
      default: begin
        state_n = STABLE_LO;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
    end
  end

`ifdef GATE_DEBOUNCE_EDGE_EN
  // Pulse is registered alongside the WAIT_HI -> STABLE_HI step.
  logic rise_n;

  assign rise_n = (state == WAIT_HI) && s2 && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) rise <= 1'b0;
    else     rise <= rise_n;
  end
`else
  assign rise = 1'b0;
`endif

endmodule

module gate_input_debounce #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din_a_raw,
  input  logic din_b_raw,
  output logic din_a,
  output logic din_b,
  output logic rise_a,
  output logic rise_b
);

  gate_input_debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (din_a_raw),
    .level(din_a),
    .rise (rise_a)
  );

  gate_input_debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (din_b_raw),
    .level(din_b),
    .rise (rise_b)
  );

endmodule

// File: tb/tb_gate_input_debounce.sv
// Bench for gate_input_debounce: run-length model plus directed checks.
// Rise expectations follow GATE_DEBOUNCE_EDGE_EN.

module tb_gate_input_debounce;

  localparam int N = 4;
`ifdef GATE_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din_a_raw;
  logic din_b_raw;
  logic din_a;
  logic din_b;
  logic rise_a;
  logic rise_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_input_debounce #(
    .STABLE_CNT(N),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_a_raw(din_a_raw),
    .din_b_raw(din_b_raw),
    .din_a    (din_a),
    .din_b    (din_b),
    .rise_a   (rise_a),
    .rise_b   (rise_b)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: the FSM sees the raw level two edges late and follows it
  // once that level has been seen on N consecutive edges.
  logic [1:0] m_d1, m_d2, m_last, m_lvl, m_rise;
  int         m_run [2];

  task automatic model_ch(input int c, input logic raw);
    logic smp;
    smp = m_d2[c];
    m_d2[c] = m_d1[c];
    m_d1[c] = raw;
    m_run[c] = (smp == m_last[c]) ? m_run[c] + 1 : 1;
    m_last[c] = smp;
    m_rise[c] = 1'b0;
    if (smp != m_lvl[c] && m_run[c] >= N) begin
      m_lvl[c]  = smp;
      m_rise[c] = smp & EDGE;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_last = '0;
      m_lvl = '0; m_rise = '0;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      model_ch(0, din_a_raw);
      model_ch(1, din_b_raw);
    end
    #2;
    chk("m_din_a", din_a, m_lvl[0]);
    chk("m_din_b", din_b, m_lvl[1]);
    chk("m_rise_a", rise_a, m_rise[0]);
    chk("m_rise_b", rise_b, m_rise[1]);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    din_a_raw = 1'b1;
    din_b_raw = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_din_a", din_a, 1'b0);
      chk("rst_din_b", din_b, 1'b0);
      chk("rst_rise_a", rise_a, 1'b0);
      chk("rst_rise_b", rise_b, 1'b0);
    end
    @(negedge clk) rst = 1'b0;
    step(5);
    chk("rel_e5_din_a", din_a, 1'b0);
    chk("rel_e5_din_b", din_b, 1'b0);
    step(1);
    chk("rel_e6_din_a", din_a, 1'b1);
    chk("rel_e6_din_b", din_b, 1'b1);
    chk("rel_e6_rise_a", rise_a, EDGE);
    step(1);
    chk("rel_e7_rise_a", rise_a, 1'b0);

    @(negedge clk);
    din_a_raw = 1'b0;
    din_b_raw = 1'b0;
    step(10);
    chk("idle_din_a", din_a, 1'b0);
    chk("idle_din_b", din_b, 1'b0);

    @(negedge clk) din_a_raw = 1'b1;
    step(5);
    chk("step_e5_din_a", din_a, 1'b0);
    step(1);
    chk("step_e6_din_a", din_a, 1'b1);
    chk("step_e6_rise_a", rise_a, EDGE);
    chk("step_e6_din_b", din_b, 1'b0);
    step(1);
    chk("step_e7_rise_a", rise_a, 1'b0);
    chk("step_e7_din_a", din_a, 1'b1);

    @(negedge clk) din_a_raw = 1'b0;
    step(10);
    chk("pre_bnc_din_a", din_a, 1'b0);
    @(negedge clk) din_a_raw = 1'b1;
    repeat (3) @(negedge clk);
    din_a_raw = 1'b0;
    @(negedge clk) din_a_raw = 1'b1;
    repeat (2) @(negedge clk);
    din_a_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("bnc_din_a", din_a, 1'b0);
      chk("bnc_rise_a", rise_a, 1'b0);
    end

    @(negedge clk);
    din_a_raw = 1'b1;
    din_b_raw = 1'b1;
    step(5);
    chk("sim_e5_and", din_a | din_b, 1'b0);
    step(1);
    chk("sim_e6_din_a", din_a, 1'b1);
    chk("sim_e6_din_b", din_b, 1'b1);
    chk("sim_e6_and", din_a & din_b, 1'b1);
    chk("sim_e6_rise_a", rise_a, EDGE);
    chk("sim_e6_rise_b", rise_b, EDGE);
    step(1);
    chk("sim_e7_rise_b", rise_b, 1'b0);

    @(negedge clk) din_a_raw = 1'b0;
    step(5);
    chk("fall_e5_din_a", din_a, 1'b1);
    step(1);
    chk("fall_e6_din_a", din_a, 1'b0);
    chk("fall_e6_rise_a", rise_a, 1'b0);
    chk("fall_e6_din_b", din_b, 1'b1);

    step(4);
    @(negedge clk) din_a_raw = 1'b1;
    step(3);
    @(negedge clk) rst = 1'b1;
    step(1);
    chk("mrst_din_a", din_a, 1'b0);
    chk("mrst_din_b", din_b, 1'b0);
    chk("mrst_rise_a", rise_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    din_a_raw = 1'b0;
    din_b_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("mrst_hold_din_a", din_a, 1'b0);
      chk("mrst_hold_rise_a", rise_a, 1'b0);
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
